// File: rtl/mmu_pkg.sv
// Shared MMU definitions: TLB op encodings, sequencer states and packed-entry layout.
package mmu_pkg;

  typedef enum logic [1:0] {
    OP_TLBR  = 2'd0,
    OP_TLBWI = 2'd1,
    OP_TLBWR = 2'd2,
    OP_TLBP  = 2'd3
  } op_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_PROBE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam int ENTRY_W      = 90;
  localparam int PAGEMASK_LSB = 78;
  localparam int PAGEMASK_W   = 12;
  localparam int VPN2_LSB     = 59;
  localparam int VPN2_W       = 19;
  localparam int ASID_LSB     = 51;
  localparam int ASID_W       = 8;
  localparam int G_BIT        = 50;
  localparam int LO0_LSB      = 25;
  localparam int LO1_LSB      = 0;
  localparam int LO_W         = 25;
  localparam int PROBE_PAD_W  = 13;

  localparam int TLBP_MISS_BIT = 31;

  function automatic logic [31:0] probe_addr(input logic [ENTRY_W-1:0] entry);
    return {entry[VPN2_LSB +: VPN2_W], {PROBE_PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/tlb_op_sequencer_random.sv
// Random register: counts down from the top index, wraps at or below Wired, forced to the top on a Wired write.
module tlb_random_counter
  import mmu_pkg::*;
#(
  parameter int              IDX_W        = 5,
  parameter logic [IDX_W-1:0] RANDOM_RESET = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_wr,
  output logic [IDX_W-1:0] random
);

  always_ff @(posedge clk) begin
    if (rst) begin
      random <= RANDOM_RESET;
    end else if (wired_wr || (random <= wired)) begin
      random <= RANDOM_RESET;
    end else begin
      random <= random - IDX_W'(1);
    end
  end

endmodule

// File: rtl/tlb_op_sequencer.sv
// CP0 TLB maintenance sequencer (TLBR/TLBWI/TLBWR/TLBP) driving the MMU TLB port.
// Optional flush pulse after TLB writes when TLB_OP_FLUSH_EN is defined.
//   state | meaning
//   IDLE  | ready, accepts an op
//   READ  | phase 0 issue rtlb, phase 1 capture tlbr_result
//   WRITE | single wtlb strobe
//   PROBE | phase 0 issue, phase 1 sample tlbp_result, phase 2 settle
//   DONE  | op_done plus write-back strobe
module tlb_op_sequencer
  import mmu_pkg::*;
#(
  parameter  int TLB_ENTRIES  = 32,
  parameter  int RANDOM_RESET = TLB_ENTRIES - 1,
  localparam int IDX_W        = $clog2(TLB_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [1:0]         op_type,
  output logic               op_ready,
  output logic               stall_o,
  input  logic [IDX_W-1:0]   cp0_index,
  input  logic [IDX_W-1:0]   cp0_wired,
  input  logic               wired_wr,
  input  logic [ENTRY_W-1:0] cp0_entry,
  output logic               rtlb,
  output logic               wtlb,
  output logic [IDX_W-1:0]   tlb_addr,
  output logic [ENTRY_W-1:0] tlb_wdata,
  output logic [31:0]        probe_vaddr,
  output logic               probe_sel,
  input  logic [ENTRY_W-1:0] tlbr_result,
  input  logic [31:0]        tlbp_result,
  output logic               op_done,
  output logic               entry_we,
  output logic [ENTRY_W-1:0] entry_wdata,
  output logic               index_we,
  output logic [31:0]        index_wdata,
  output logic [IDX_W-1:0]   random_o
`ifdef TLB_OP_FLUSH_EN
  ,
  output logic               flush_o
`endif
);

  localparam logic [1:0] READ_CAP  = 2'd1;
  localparam logic [1:0] PROBE_CAP = 2'd1;
  localparam logic [1:0] PROBE_END = 2'd2;

  seq_state_e          state_q, state_d;
  logic [1:0]          phase_q;
  op_type_e            op_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ENTRY_W-1:0]  entry_q;
  logic [ENTRY_W-1:0]  entry_wdata_q;
  logic [31:0]         index_wdata_q;
  logic                accept;

  assign accept = op_valid && (state_q == ST_IDLE);

  tlb_random_counter #(
    .IDX_W        (IDX_W),
    .RANDOM_RESET (IDX_W'(RANDOM_RESET))
  ) u_random (
    .clk      (clk),
    .rst      (rst),
    .wired    (cp0_wired),
    .wired_wr (wired_wr),
    .random   (random_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= 2'd0;
    end else begin
      state_q <= state_d;
      phase_q <= (state_d != state_q) ? 2'd0 : phase_q + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_type)
            OP_TLBR:  state_d = ST_READ;
            OP_TLBP:  state_d = ST_PROBE;
            default:  state_d = ST_WRITE;
          endcase
        end
      end
      ST_READ:  if (phase_q == READ_CAP)  state_d = ST_DONE;
      ST_WRITE: state_d = ST_DONE;
      ST_PROBE: if (phase_q == PROBE_END) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state_q == ST_IDLE);
    stall_o   = (state_q != ST_IDLE) || op_valid;
    rtlb      = 1'b0;
    wtlb      = 1'b0;
    probe_sel = 1'b0;
    op_done   = 1'b0;
    entry_we  = 1'b0;
    index_we  = 1'b0;
    case (state_q)
      ST_READ:  rtlb      = (phase_q == 2'd0);
      ST_WRITE: wtlb      = 1'b1;
      ST_PROBE: probe_sel = (phase_q != PROBE_END);
      ST_DONE: begin
        op_done  = 1'b1;
        entry_we = (op_q == OP_TLBR);
        index_we = (op_q == OP_TLBP);
      end
      default: ;
    endcase
  end

  // TLBWR targets the Random value seen at accept; Random keeps moving while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= OP_TLBR;
      idx_q         <= '0;
      entry_q       <= '0;
      entry_wdata_q <= '0;
      index_wdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_type_e'(op_type);
        entry_q <= cp0_entry;
        idx_q   <= (op_type == OP_TLBWR) ? random_o : cp0_index;
      end
      if ((state_q == ST_READ) && (phase_q == READ_CAP))
        entry_wdata_q <= tlbr_result;
      if ((state_q == ST_PROBE) && (phase_q == PROBE_CAP))
        index_wdata_q <= tlbp_result;
    end
  end

  assign tlb_addr    = idx_q;
  assign tlb_wdata   = entry_q;
  assign probe_vaddr = probe_addr(entry_q);
  assign entry_wdata = entry_wdata_q;
  assign index_wdata = index_wdata_q;

`ifdef TLB_OP_FLUSH_EN
  // WRITE always leads to DONE, so this flop lines up with op_done.
  always_ff @(posedge clk) begin
    if (rst) flush_o <= 1'b0;
    else     flush_o <= (state_q == ST_WRITE);
  end
`endif

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer with a small behavioural TLB behind the MMU port.
module tb_tlb_op_sequencer;
  import mmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_type;
  logic        op_ready, stall_o;
  logic [4:0]  cp0_index, cp0_wired;
  logic        wired_wr;
  logic [89:0] cp0_entry;
  logic        rtlb, wtlb;
  logic [4:0]  tlb_addr;
  logic [89:0] tlb_wdata;
  logic [31:0] probe_vaddr;
  logic        probe_sel;
  logic [89:0] tlbr_q;
  logic [31:0] tlbp_q;
  logic        op_done, entry_we, index_we;
  logic [89:0] entry_wdata;
  logic [31:0] index_wdata;
  logic [4:0]  random_o;
`ifdef TLB_OP_FLUSH_EN
  logic        flush_o;
`endif

  logic [89:0] mem [32];
  logic [31:0] pr;
  logic [4:0]  exp_rand;
  logic [4:0]  exp_idx;
  int          wcnt = 0;
  int          ecnt = 0;
  int          ecnt_before;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [89:0] entry_a, entry_b, entry_m;

  tlb_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_type     (op_type),
    .op_ready    (op_ready),
    .stall_o     (stall_o),
    .cp0_index   (cp0_index),
    .cp0_wired   (cp0_wired),
    .wired_wr    (wired_wr),
    .cp0_entry   (cp0_entry),
    .rtlb        (rtlb),
    .wtlb        (wtlb),
    .tlb_addr    (tlb_addr),
    .tlb_wdata   (tlb_wdata),
    .probe_vaddr (probe_vaddr),
    .probe_sel   (probe_sel),
    .tlbr_result (tlbr_q),
    .tlbp_result (tlbp_q),
    .op_done     (op_done),
    .entry_we    (entry_we),
    .entry_wdata (entry_wdata),
    .index_we    (index_we),
    .index_wdata (index_wdata),
    .random_o    (random_o)
`ifdef TLB_OP_FLUSH_EN
    ,
    .flush_o     (flush_o)
`endif
  );

  always #5 clk = ~clk;

  // Registered-read TLB model; probe returns lowest matching index or the miss bit.
  always @(posedge clk) begin
    if (rtlb) tlbr_q <= mem[tlb_addr];
    if (wtlb) begin
      mem[tlb_addr] <= tlb_wdata;
      wcnt <= wcnt + 1;
    end
    if (probe_sel) begin
      pr = 32'h8000_0000;
      for (int i = 31; i >= 0; i--)
        if (mem[i][77:59] == probe_vaddr[31:13]) pr = 32'(i);
      tlbp_q <= pr;
    end
    if (entry_we) ecnt <= ecnt + 1;
  end

  always @(posedge clk) begin
    if (rst)                                  exp_rand <= 5'd31;
    else if (wired_wr || exp_rand <= cp0_wired) exp_rand <= 5'd31;
    else                                      exp_rand <= exp_rand - 5'd1;
  end

  task automatic chk(input string tag, input logic [89:0] obs, input logic [89:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    tlbr_q = '0;
    tlbp_q = '0;
    entry_a = {12'h0ff, 19'h12345, 8'h3c, 1'b1, 25'h0abcdef, 25'h1234567};
    entry_b = {12'h000, 19'h0abcd, 8'h11, 1'b0, 25'h0000101, 25'h0000303};
    entry_m = entry_a;
    entry_m[77:59] = 19'h00777;
    rst = 1'b1; op_valid = 1'b0; op_type = 2'd0; cp0_index = '0;
    cp0_wired = 5'd28; wired_wr = 1'b0; cp0_entry = '0;
    step(); step();

    chk("rst_ready", op_ready, 1);
    chk("rst_stall", stall_o, 0);
    chk("rst_rtlb", rtlb, 0);
    chk("rst_wtlb", wtlb, 0);
    chk("rst_probe_sel", probe_sel, 0);
    chk("rst_done", op_done, 0);
    chk("rst_entry_we", entry_we, 0);
    chk("rst_index_we", index_we, 0);
    chk("rst_random", random_o, 31);
    chk("rst_addr", tlb_addr, 0);
    chk("rst_wdata", tlb_wdata, 0);
    chk("rst_vaddr", probe_vaddr, 0);
    chk("rst_entry_wdata", entry_wdata, 0);
    chk("rst_index_wdata", index_wdata, 0);
`ifdef TLB_OP_FLUSH_EN
    chk("rst_flush", flush_o, 0);
`endif
    rst = 1'b0;

    step(); chk("rand_30", random_o, 30);
    step(); chk("rand_29", random_o, 29);
    step(); chk("rand_28", random_o, 28);
    step(); chk("rand_wrap", random_o, 31);
    step(); chk("rand_30b", random_o, 30);
    wired_wr = 1'b1;
    step(); chk("rand_wired_wr", random_o, 31);
    wired_wr = 1'b0;
    step(); chk("rand_after_wr", random_o, 30);

    // TLBWI to index 5; inputs change after accept to prove latching
    cp0_index = 5'd5; cp0_entry = entry_a; op_type = OP_TLBWI; op_valid = 1'b1;
    #1;
    chk("wi_stall_accept", stall_o, 1);
    chk("wi_ready_accept", op_ready, 1);
    step();
    op_valid = 1'b0; cp0_entry = ~entry_a; cp0_index = 5'd9;
    #1;
    chk("wi_wtlb", wtlb, 1);
    chk("wi_addr", tlb_addr, 5);
    chk("wi_wdata", tlb_wdata, entry_a);
    chk("wi_done_early", op_done, 0);
    chk("wi_ready_busy", op_ready, 0);
    step();
    chk("wi_done", op_done, 1);
    chk("wi_wtlb_off", wtlb, 0);
    chk("wi_entry_we", entry_we, 0);
    chk("wi_index_we", index_we, 0);
    chk("wi_stall_done", stall_o, 1);
`ifdef TLB_OP_FLUSH_EN
    chk("wi_flush", flush_o, 1);
`endif
    step();
    chk("wi_idle_ready", op_ready, 1);
    chk("wi_idle_stall", stall_o, 0);
    chk("wi_idle_done", op_done, 0);
    chk("wi_wtlb_count", wcnt, 1);
    chk("wi_mem5", mem[5], entry_a);

    // TLBR back from index 5
    cp0_index = 5'd5; cp0_entry = '0; op_type = OP_TLBR; op_valid = 1'b1;
    step();
    op_valid = 1'b0; cp0_index = 5'd0;
    #1;
    chk("rd_rtlb", rtlb, 1);
    chk("rd_addr", tlb_addr, 5);
    chk("rd_done_c1", op_done, 0);
    step();
    chk("rd_done_c2", op_done, 0);
    step();
    chk("rd_done", op_done, 1);
    chk("rd_entry_we", entry_we, 1);
    chk("rd_vpn2", entry_wdata[77:59], 19'h12345);
    chk("rd_entry", entry_wdata, entry_a);
    chk("rd_index_we", index_we, 0);
    step();
    chk("rd_idle", op_ready, 1);

    // TLBP hit on VPN2 0x12345
    cp0_entry = entry_a; op_type = OP_TLBP; op_valid = 1'b1;
    step();
    op_valid = 1'b0; cp0_entry = '0;
    #1;
    chk("ph_sel_c1", probe_sel, 1);
    chk("ph_vaddr", probe_vaddr, 32'h2468_A000);
    step();
    chk("ph_sel_c2", probe_sel, 1);
    chk("ph_done_c2", op_done, 0);
    step();
    chk("ph_done_c3", op_done, 0);
    step();
    chk("ph_done", op_done, 1);
    chk("ph_index_we", index_we, 1);
    chk("ph_index", index_wdata, 32'h0000_0005);
    chk("ph_entry_we", entry_we, 0);
`ifdef TLB_OP_FLUSH_EN
    chk("ph_flush", flush_o, 0);
`endif
    step();

    // TLBP miss
    cp0_entry = entry_m; op_type = OP_TLBP; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    step(); step(); step();
    chk("pm_done", op_done, 1);
    chk("pm_index_we", index_we, 1);
    chk("pm_index", index_wdata, 32'h8000_0000);
    step();

    // TLBWR with Wired=0; a TLBR held on op_valid while busy must be ignored
    cp0_wired = 5'd0;
    step(); step(); step();
    chk("wr_rand_model", random_o, exp_rand);
    exp_idx = exp_rand;
    cp0_entry = entry_b; op_type = OP_TLBWR; op_valid = 1'b1;
    step();
    op_type = OP_TLBR;
    #1;
    chk("wr_wtlb", wtlb, 1);
    chk("wr_addr", tlb_addr, exp_idx);
    chk("wr_wdata", tlb_wdata, entry_b);
    step();
    chk("wr_done", op_done, 1);
    chk("wr_addr_hold", tlb_addr, exp_idx);
    chk("wr_no_rtlb", rtlb, 0);
    chk("wr_rand_moving", random_o, exp_rand);
    op_valid = 1'b0;
    #1;
    step();
    chk("wr_idle", op_ready, 1);
    chk("wr_idle_rtlb", rtlb, 0);
    chk("wr_idle_stall", stall_o, 0);
    chk("wr_mem", mem[exp_idx], entry_b);

    // Reset while in READ
    cp0_index = 5'd5; op_type = OP_TLBR; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    #1;
    chk("rr_rtlb", rtlb, 1);
    ecnt_before = ecnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rr_ready", op_ready, 1);
    chk("rr_stall", stall_o, 0);
    chk("rr_rtlb_off", rtlb, 0);
    chk("rr_random", random_o, 31);
    step(); step(); step();
    chk("rr_no_entry_we", ecnt, ecnt_before);
    chk("rr_entry_we_total", ecnt, 1);
    chk("rr_done", op_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tlb_op_sequencer.md
# tlb_op_sequencer

Multi-cycle controller that executes the CP0 TLB maintenance instructions (TLBR, TLBWI, TLBWR, TLBP) against the 32-entry TLB inside the MMU. It sits between the MEM-stage CP0 logic and the MMU's `rtlb`/`wtlb`/`tlb_addr`/`tlb_wdata` port. It stalls the pipeline while an operation is in flight and owns the Random register. Results return to CP0 as write-back pulses.

## Interface
Parameters:
- `TLB_ENTRIES`, 32: TLB depth; index width is log2 of this (5).
- `RANDOM_RESET`, 31: Random register reset value (`TLB_ENTRIES-1`).

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `op_valid` input 1: MEM stage presents a TLB instruction.
- `op_type` input 2: 0 = TLBR, 1 = TLBWI, 2 = TLBWR, 3 = TLBP.
- `op_ready` output 1: high only in IDLE. An operation is accepted when `op_valid && op_ready`.
- `stall_o` output 1: pipeline hold. High from acceptance through the DONE cycle.
- `cp0_index` input 5: Index[4:0].
- `cp0_wired` input 5: Wired[4:0].
- `wired_wr` input 1: CP0 write to Wired this cycle.
- `cp0_entry` input 90: packed entry built from PageMask/EntryHi/EntryLo0/EntryLo1.
- `rtlb`, `wtlb` output 1: MMU strobes.
- `tlb_addr` output 5: MMU entry index.
- `tlb_wdata` output 90: MMU write data.
- `probe_vaddr` output 32: `{VPN2, 13'b0}` driven onto the MMU data lookup port during PROBE.
- `probe_sel` output 1: muxes `probe_vaddr` onto the data lookup port.
- `tlbr_result` input 90, `tlbp_result` input 32: MMU results.
- `op_done` output 1: one-cycle completion pulse.
- `entry_we` output 1, `entry_wdata` output 90: TLBR write-back to CP0.
- `index_we` output 1, `index_wdata` output 32: TLBP write-back; bit31 = P, bits[4:0] = index.
- `random_o` output 5: current Random value.

Packed entry layout (90 bits): [89:78] PageMask, [77:59] VPN2, [58:51] ASID, [50] G, [49:25] {PFN0[19:0], C0[2:0], D0, V0}, [24:0] {PFN1, C1, D1, V1}.

## Operation
- FSM states: IDLE, READ, WRITE, PROBE, DONE.
- From IDLE on accept:
  - TLBR goes to READ.
  - TLBWI and TLBWR go to WRITE.
  - TLBP goes to PROBE.
- `cp0_entry`, the target index and `op_type` are latched at accept. The index is `cp0_index` for TLBR/TLBWI and `random_o` for TLBWR.
- READ: `rtlb`=1, `tlb_addr`=latched index. Next cycle: capture `tlbr_result`, go to DONE.
- WRITE: `wtlb`=1 for exactly one cycle with the latched index and entry, then DONE.
- PROBE: `probe_sel`=1 and `probe_vaddr` valid for two cycles (issue + sample). `tlbp_result` is captured on the second cycle, then DONE.
- DONE: `op_done`=1, plus the matching write-back strobe (`entry_we` for TLBR, `index_we` for TLBP). `stall_o` drops next cycle; return to IDLE.
- Random register:
  - Decrements every cycle.
  - When it equals `cp0_wired`, or is below it, the next value is 31 (wrap).
  - `wired_wr` forces 31 on the next edge; this has priority over the decrement.
  - Random keeps counting while busy; TLBWR uses the value latched at accept.
  - If `cp0_wired` = 31, Random holds 31.
- `op_valid` while not in IDLE is ignored. The stall guarantees the MEM stage re-presents nothing new.
- A reset during an operation returns to IDLE at the next edge. Strobes deassert at that edge, no write-back occurs and any partial write is abandoned. No TLB write happens unless the WRITE cycle fully completed.

## Timing
- Reset values: state IDLE, `op_ready`=1, Random=31. All strobes (`rtlb`, `wtlb`, `probe_sel`, `op_done`, `entry_we`, `index_we`, `stall_o`) are 0. All data outputs are 0.
- Latency from accept to `op_done`:
  - TLBWI/TLBWR: 2 cycles.
  - TLBR: 3 cycles.
  - TLBP: 4 cycles.
- `stall_o` is combinational on accept (high in the accept cycle) so the MEM stage holds without a bubble.
- All write-back data is registered; CP0 samples it on the edge that ends DONE.
- Back-to-back operations: the next accept is possible on the cycle after DONE.

## Configuration
- `TLB_OP_FLUSH_EN` defined:
  - Adds output `flush_o` (1 bit), registered and 0 at reset.
  - `flush_o` pulses together with `op_done` after TLBWI/TLBWR so fetch can refetch under the new mapping.
- Undefined: the port is absent and no flush is generated.

## Structure
- Shared package `mmu_pkg` holds:
  - the `op_type` encodings;
  - the FSM state enum;
  - the packed-entry field offsets and widths;
  - `TLBP_MISS_BIT` = 31.
- One sub-module, `tlb_random_counter`, contains the Random/Wired logic with its own `clk`/`rst`.

## Test plan
- TLBWI: reset, Index=5, entry VPN2=0x12345 -> `wtlb` high exactly once with `tlb_addr`=5 and the entry bits; `op_done` 2 cycles after accept.
- TLBR: after the above write, TLBR with Index=5 -> `entry_we` with VPN2 field = 0x12345 at cycle +3.
- TLBP hit and miss:
  - Probe VPN2 0x12345 -> `index_wdata` = 0x00000005.
  - Probe an absent VPN2 -> bit31 = 1.
- Random sequence: Wired=28 from reset -> Random sequence 31, 30, 29, 28, 31. `wired_wr` mid-sequence -> 31 next cycle. TLBWR writes to the index latched at accept.
- Reset while in READ -> IDLE next cycle, no `entry_we`, `stall_o`=0.
- With `TLB_OP_FLUSH_EN`: `flush_o` coincides with `op_done` for TLBWI and is absent for TLBP.
